prpg_engine: RTL and testbench
==============================

PRPG_ENGINE -- requirements
Module: prpg_engine

Interface
REQ-001 Parameter W, default 8: LFSR width in bits; legal range 4..32.
REQ-002 Parameter DEPTH, default 256: number of pattern-memory entries; power of two, 2..1024. AW = clog2(DEPTH).
REQ-003 Parameter SEED_RST, default all ones (W bits): value loaded into p at reset.
REQ-004 Parameter TAP_RST, default 0 (W-1 bits): value loaded into the tap register at reset.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 instr_valid  input  1  instruction present.
REQ-008 instr_op  input  4  opcode.
REQ-009 instr_arg  input  W  operand.
REQ-010 instr_ready  output  1  engine accepts an instruction this cycle.
REQ-011 p  output  W  current LFSR state.
REQ-012 p_next  output  W  combinational single-step successor of p.
REQ-013 hd  output  clog2(W+1)  Hamming distance between p and p_next, computed combinationally.
REQ-014 step_pulse  output  1  high for one cycle after every edge on which p advanced by one LFSR step.
REQ-015 halted  output  1  high once HALT has been accepted.

Function
REQ-016 An instruction is accepted on a rising edge where instr_valid and instr_ready are both 1; if instr_ready is 0, instr_valid is ignored.
REQ-017 LFSR step (Galois, internal XOR): p'[0] = p[W-1]; for k = 1..W-1, p'[k] = p[k-1] XOR (tap[k-1] AND p[W-1]); p_next SHALL equal p'.
REQ-018 Opcode 0 HALT: set halted=1 and instr_ready=0; the engine then holds all state until reset.
REQ-019 Opcode 1 CONFIG: tap <= instr_arg[W-2:0]; single cycle.
REQ-020 Opcode 2 INIT: p <= instr_arg; single cycle.
REQ-021 Opcode 3 RUN n (n = instr_arg):
- n = 0 is a one-cycle no-op; p is unchanged and no step_pulse is generated.
- For n >= 1, p steps on the accept edge and on each of the following n-1 edges, giving exactly n steps at one step per cycle.
- instr_ready is 0 from the accept edge until the edge of the final step; it returns to 1 after that edge.
REQ-022 The state machine has states IDLE, RUN and HALT.
- IDLE -> RUN on accepting RUN with n >= 2; RUN holds a remaining-step counter.
- RUN -> IDLE on the edge where the counter reaches zero.
- IDLE -> HALT on accepting HALT.
REQ-023 Opcode 4 INIT_ADDR: addr <= instr_arg[AW-1:0], zero-extended when W < AW.
REQ-024 Opcode 6 ADD_ADDR: addr <= (addr + instr_arg) mod DEPTH; wrap-around is silent.
REQ-025 Opcode 5 ST_P: mem[addr] <= p.
REQ-026 Opcode 8 ST_HD: mem[addr] <= hd, zero-extended to W bits.
REQ-027 Opcode 7 LD: p <= mem[addr], visible the cycle after the accept edge.
REQ-028 Every opcode other than RUN and HALT completes in one cycle, with instr_ready remaining 1. Opcodes 9..15 are no-ops.
REQ-029 Tap value 0 makes the step a pure rotation. A seed of all zeros holds p at zero with hd = 0, which is legal.
REQ-030 hd and p_next track p and tap combinationally in every state, including RUN.

Reset
REQ-031 While rst_n = 0:
- p = SEED_RST, tap = TAP_RST, addr = 0;
- state = IDLE, step counter = 0;
- halted = 0, step_pulse = 0, instr_ready = 1 after release.
REQ-032 Reset asserted mid-RUN aborts the run immediately; no further steps occur.
REQ-033 Memory contents are not reset; reading an unwritten entry returns an undefined value.

Verification (W=8, DEPTH=256)
REQ-034 Reset, CONFIG 0x1D -> p = 0xFF, p_next = 0xC5, hd = 4.
REQ-035 CONFIG 0x1D, INIT 0x01, RUN 3 -> p = 0x02, 0x04, 0x08 on successive edges; three step_pulses; instr_ready low for 2 cycles.
REQ-036 INIT_ADDR 0xFE, ADD_ADDR 0x03, ST_P with p = 0xA5, INIT 0x00, LD -> addr = 0x01 and p = 0xA5.
REQ-037 RUN 10 with rst_n pulsed low after the 4th step -> p = 0xFF, instr_ready = 1, no further step_pulse.
REQ-038 RUN 0 -> p unchanged, instr_ready stays 1. HALT then INIT 0x33 -> halted = 1, instr_ready = 0, p unchanged.
REQ-039 With p = 0xFF and tap 0x1D, ST_HD at addr 5, then LD -> p = 0x04.

Source files
------------

// File: rtl/prpg_engine.sv
// Programmable pseudo-random pattern generator: a Galois LFSR driven by a small
// instruction stream, with a pattern memory for storing states and distances.
module prpg_engine #(
    parameter int             W        = 8,
    parameter int             DEPTH    = 256,
    parameter logic [W-1:0]   SEED_RST = {W{1'b1}},
    parameter logic [W-2:0]   TAP_RST  = {(W-1){1'b0}}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instr_valid,
    input  logic [3:0]             instr_op,
    input  logic [W-1:0]           instr_arg,
    output logic                   instr_ready,
    output logic [W-1:0]           p,
    output logic [W-1:0]           p_next,
    output logic [$clog2(W+1)-1:0] hd,
    output logic                   step_pulse,
    output logic                   halted
);
    localparam int AW  = $clog2(DEPTH);
    localparam int HDW = $clog2(W+1);

    localparam logic [3:0] OP_HALT     = 4'd0;
    localparam logic [3:0] OP_CONFIG   = 4'd1;
    localparam logic [3:0] OP_INIT     = 4'd2;
    localparam logic [3:0] OP_RUN      = 4'd3;
    localparam logic [3:0] OP_INIT_ADR = 4'd4;
    localparam logic [3:0] OP_ST_P     = 4'd5;
    localparam logic [3:0] OP_ADD_ADR  = 4'd6;
    localparam logic [3:0] OP_LD       = 4'd7;
    localparam logic [3:0] OP_ST_HD    = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur, input logic [W-2:0] taps);
        return {cur[W-2:0], cur[W-1]} ^ ({taps, 1'b0} & {W{cur[W-1]}});
    endfunction

    function automatic logic [HDW-1:0] popcount(input logic [W-1:0] v);
        logic [HDW-1:0] n;
        n = {HDW{1'b0}};
        for (int i = 0; i < W; i++) begin
            n = n + {{(HDW-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

    state_t          state_r, state_nxt_s;
    logic [W-1:0]    p_r, p_nxt_s;
    logic [W-2:0]    tap_r, tap_nxt_s;
    logic [AW-1:0]   addr_r, addr_nxt_s, addr_arg_s;
    logic [W-1:0]    cnt_r, cnt_nxt_s;
    logic            ready_r, halted_r, step_pulse_r;
    logic            step_s, mem_we_s;
    logic [W-1:0]    mem_wdata_s, mem_rdata_s, p_step_s;
    logic [HDW-1:0]  hd_s;
    logic [W-1:0]    mem_r [DEPTH];

    // Operand-to-address mapping: truncate wide operands, zero-extend narrow ones.
    generate
        if (W >= AW) begin : g_addr_trunc
            assign addr_arg_s = instr_arg[AW-1:0];
        end else begin : g_addr_ext
            assign addr_arg_s = {{(AW-W){1'b0}}, instr_arg};
        end
    endgenerate

    assign p_step_s    = lfsr_step(p_r, tap_r);
    assign hd_s        = popcount(p_r ^ p_step_s);
    assign mem_rdata_s = mem_r[addr_r];

    assign p           = p_r;
    assign p_next      = p_step_s;
    assign hd          = hd_s;
    assign instr_ready = ready_r;
    assign step_pulse  = step_pulse_r;
    assign halted      = halted_r;

    // Instruction decode and next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        p_nxt_s     = p_r;
        tap_nxt_s   = tap_r;
        addr_nxt_s  = addr_r;
        cnt_nxt_s   = cnt_r;
        step_s      = 1'b0;
        mem_we_s    = 1'b0;
        mem_wdata_s = p_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    case (instr_op)
                        OP_HALT:     state_nxt_s = ST_HALT;
                        OP_CONFIG:   tap_nxt_s   = instr_arg[W-2:0];
                        OP_INIT:     p_nxt_s     = instr_arg;
                        OP_RUN: begin
                            if (instr_arg != {W{1'b0}}) begin
                                step_s  = 1'b1;
                                p_nxt_s = p_step_s;
                                // A single step completes on the accept edge; longer runs park in RUN.
                                if (instr_arg != {{(W-1){1'b0}}, 1'b1}) begin
                                    state_nxt_s = ST_RUN;
                                    cnt_nxt_s   = instr_arg - {{(W-1){1'b0}}, 1'b1};
                                end else begin
                                    cnt_nxt_s   = {W{1'b0}};
                                end
                            end else begin
                                step_s = 1'b0;
                            end
                        end
                        OP_INIT_ADR: addr_nxt_s  = addr_arg_s;
                        OP_ADD_ADR:  addr_nxt_s  = addr_r + addr_arg_s;
                        OP_ST_P:     mem_we_s    = 1'b1;
                        OP_LD:       p_nxt_s     = mem_rdata_s;
                        OP_ST_HD: begin
                            mem_we_s    = 1'b1;
                            mem_wdata_s = {{(W-HDW){1'b0}}, hd_s};
                        end
                        default:     state_nxt_s = ST_IDLE;
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s    = 1'b1;
                p_nxt_s   = p_step_s;
                cnt_nxt_s = cnt_r - {{(W-1){1'b0}}, 1'b1};
                if (cnt_r <= {{(W-1){1'b0}}, 1'b1}) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Architectural state and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            p_r          <= SEED_RST;
            tap_r        <= TAP_RST;
            addr_r       <= {AW{1'b0}};
            cnt_r        <= {W{1'b0}};
            ready_r      <= 1'b1;
            halted_r     <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            p_r          <= p_nxt_s;
            tap_r        <= tap_nxt_s;
            addr_r       <= addr_nxt_s;
            cnt_r        <= cnt_nxt_s;
            ready_r      <= (state_nxt_s == ST_IDLE);
            halted_r     <= (state_nxt_s == ST_HALT);
            step_pulse_r <= step_s;
        end
    end

    // Pattern memory write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[addr_r] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_prpg_engine.sv
// Randomized scoreboard bench for prpg_engine (W=8, DEPTH=256): a behavioural
// model predicts the outputs after every clock edge and a monitor compares them.
module tb_prpg_engine;
    localparam int W     = 8;
    localparam int DEPTH = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic [3:0] instr_op = 4'd0;
    logic [7:0] instr_arg = 8'd0;
    logic       instr_ready, step_pulse, halted;
    logic [7:0] p, p_next;
    logic [3:0] hd;

    prpg_engine #(.W(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_op(instr_op),
        .instr_arg(instr_arg), .instr_ready(instr_ready), .p(p), .p_next(p_next),
        .hd(hd), .step_pulse(step_pulse), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] p;
        logic [7:0] pn;
        logic [3:0] hd;
        logic       rdy;
        logic       pulse;
        logic       hlt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Behavioural model state
    int unsigned m_p, m_tap, m_addr, m_rem;
    bit          m_halted, m_pulse;
    int unsigned m_mem [DEPTH];
    bit          m_written [DEPTH];

    function automatic int unsigned m_step(input int unsigned v, input int unsigned t);
        int unsigned msb, r;
        msb = (v >> 7) & 1;
        r   = ((v << 1) & 32'hFF) | msb;
        if (msb != 0) r = r ^ (t << 1);
        return r & 32'hFF;
    endfunction

    function automatic int unsigned m_dist(input int unsigned a, input int unsigned b);
        int unsigned d, x;
        d = 0;
        x = a ^ b;
        for (int i = 0; i < 8; i++) d += (x >> i) & 1;
        return d;
    endfunction

    task automatic model_reset();
        m_p = 32'hFF; m_tap = 0; m_addr = 0; m_rem = 0;
        m_halted = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int unsigned op, input int unsigned arg);
        m_pulse = 1'b0;
        if (m_halted) begin
        end else if (m_rem > 0) begin
            m_p = m_step(m_p, m_tap); m_rem--; m_pulse = 1'b1;
        end else if (v) begin
            case (op)
                0: m_halted = 1'b1;
                1: m_tap = arg & 32'h7F;
                2: m_p = arg;
                3: if (arg > 0) begin m_p = m_step(m_p, m_tap); m_pulse = 1'b1; m_rem = arg - 1; end
                4: m_addr = arg % DEPTH;
                5: begin m_mem[m_addr] = m_p; m_written[m_addr] = 1'b1; end
                6: m_addr = (m_addr + arg) % DEPTH;
                7: m_p = m_mem[m_addr];
                8: begin m_mem[m_addr] = m_dist(m_p, m_step(m_p, m_tap)); m_written[m_addr] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic push_exp();
        exp_t e;
        int unsigned pn;
        pn      = m_step(m_p, m_tap);
        e.p     = m_p[7:0];
        e.pn    = pn[7:0];
        e.hd    = 4'(m_dist(m_p, pn));
        e.rdy   = (m_rem == 0) && !m_halted;
        e.pulse = m_pulse;
        e.hlt   = m_halted;
        sb_q.push_back(e);
    endtask

    task automatic cycle(input bit v, input int unsigned op, input int unsigned arg);
        instr_valid = v;
        instr_op    = op[3:0];
        instr_arg   = arg[7:0];
        @(posedge clk);
        model_edge(v, op, arg);
        push_exp();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0);
    endtask

    task automatic dcheck(input string name, input int unsigned act, input int unsigned req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        dcheck("p_during_reset", p, 32'hFF);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Monitor: one expected entry per clock edge, compared on the falling edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            vectors++;
            if (p !== mon_e.p || p_next !== mon_e.pn || hd !== mon_e.hd ||
                instr_ready !== mon_e.rdy || step_pulse !== mon_e.pulse || halted !== mon_e.hlt) begin
                miscompares++;
                $display("FAIL scoreboard t=%0t got p=%h pn=%h hd=%0d rdy=%b sp=%b hlt=%b, expected p=%h pn=%h hd=%0d rdy=%b sp=%b hlt=%b",
                         $time, p, p_next, hd, instr_ready, step_pulse, halted,
                         mon_e.p, mon_e.pn, mon_e.hd, mon_e.rdy, mon_e.pulse, mon_e.hlt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned op, arg;
        for (int i = 0; i < DEPTH; i++) m_written[i] = 1'b0;
        model_reset();
        #12;
        rst_n = 1'b1;
        idle(1);
        dcheck("reset_p", p, 32'hFF);
        dcheck("reset_ready", instr_ready, 1);

        // Reset then CONFIG 0x1D
        cycle(1'b1, 1, 32'h1D);
        dcheck("cfg_p_next", p_next, 32'hC5);
        dcheck("cfg_hd", hd, 4);

        // INIT 0x01, RUN 3
        cycle(1'b1, 2, 32'h01);
        cycle(1'b1, 3, 3);
        dcheck("run3_step1", p, 32'h02);
        dcheck("run3_ready_low", instr_ready, 0);
        idle(3);
        dcheck("run3_final", p, 32'h08);

        // Address wrap, store and reload
        cycle(1'b1, 2, 32'hA5);
        cycle(1'b1, 4, 32'hFE);
        cycle(1'b1, 6, 32'h03);
        cycle(1'b1, 5, 0);
        cycle(1'b1, 2, 32'h00);
        cycle(1'b1, 4, 32'h01);
        cycle(1'b1, 7, 0);
        dcheck("ld_wrapped_addr", p, 32'hA5);

        // Reset in the middle of RUN 10, after the 4th step
        pulse_reset();
        idle(1);
        cycle(1'b1, 1, 32'h1D);
        cycle(1'b1, 3, 10);
        idle(3);
        pulse_reset();
        idle(2);
        dcheck("abort_p", p, 32'hFF);
        dcheck("abort_ready", instr_ready, 1);
        dcheck("abort_no_pulse", step_pulse, 0);

        // ST_HD at address 5 then LD
        cycle(1'b1, 1, 32'h1D);
        cycle(1'b1, 4, 5);
        cycle(1'b1, 8, 0);
        cycle(1'b1, 7, 0);
        dcheck("st_hd_ld", p, 32'h04);

        // RUN 0 and RUN 1 boundaries, zero tap rotation, zero seed
        cycle(1'b1, 3, 0);
        dcheck("run0_ready", instr_ready, 1);
        cycle(1'b1, 3, 1);
        dcheck("run1_ready", instr_ready, 1);
        cycle(1'b1, 1, 0);
        cycle(1'b1, 2, 32'h81);
        cycle(1'b1, 3, 5);
        idle(5);
        cycle(1'b1, 2, 0);
        cycle(1'b1, 3, 4);
        idle(4);
        dcheck("zero_seed_hd", hd, 0);

        // Randomized instruction stream, HALT excluded
        for (int i = 0; i < 700; i++) begin
            op = $urandom_range(1, 15);
            if ($urandom_range(0, 3) == 0) op = $urandom_range(1, 8);
            arg = $urandom_range(0, 255);
            if (op == 3) arg = $urandom_range(0, 12);
            if (op == 7 && !m_written[m_addr]) op = 5;
            cycle($urandom_range(0, 3) != 0, op, arg);
        end
        idle(15);

        // HALT then an ignored INIT
        cycle(1'b1, 2, 32'h5A);
        cycle(1'b1, 0, 0);
        cycle(1'b1, 2, 32'h33);
        idle(2);
        dcheck("halt_flag", halted, 1);
        dcheck("halt_ready", instr_ready, 0);
        dcheck("halt_p_hold", p, 32'h5A);

        @(negedge clk);
        #1;
        dcheck("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
